// File: rtl/rvfi_retire_fifo.sv
// rvfi_retire_fifo: multi-lane RVFI retire record FIFO with all-or-nothing batch push.
// Define RVFI_ORDER_CHECK_EN to build the retire-order gap checker behind order_err_o.
module rvfi_retire_fifo #(
    parameter int NRET  = 1,
    parameter int XLEN  = 64,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic [NRET-1:0]          valid_i,
    input  logic [NRET*64-1:0]       order_i,
    input  logic [NRET*32-1:0]       insn_i,
    input  logic [NRET-1:0]          trap_i,
    input  logic [NRET*XLEN-1:0]     pc_rdata_i,
    input  logic [NRET*5-1:0]        rd_addr_i,
    input  logic [NRET*XLEN-1:0]     rd_wdata_i,
    input  logic [NRET*XLEN-1:0]     mem_addr_i,
    input  logic [NRET*XLEN/8-1:0]   mem_wmask_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [63:0]              out_order_o,
    output logic [31:0]              out_insn_o,
    output logic                     out_trap_o,
    output logic [XLEN-1:0]          out_pc_o,
    output logic [4:0]               out_rd_addr_o,
    output logic [XLEN-1:0]          out_rd_wdata_o,
    output logic [XLEN-1:0]          out_mem_addr_o,
    output logic [XLEN/8-1:0]        out_mem_wmask_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o,
    output logic [15:0]              drop_cnt_o,
    output logic                     order_err_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int MW = XLEN / 8;

    logic [63:0]   mem_order  [DEPTH];
    logic [31:0]   mem_insn   [DEPTH];
    logic          mem_trap   [DEPTH];
    logic [XLEN-1:0] mem_pc   [DEPTH];
    logic [4:0]    mem_rd     [DEPTH];
    logic [XLEN-1:0] mem_wdata [DEPTH];
    logic [XLEN-1:0] mem_addr [DEPTH];
    logic [MW-1:0] mem_wmask  [DEPTH];

    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW-1:0] lane_idx [NRET];
    logic [CW-1:0] count_q, k, free;
    logic [15:0]   drop_q, drop_sat;
    logic [16:0]   drop_sum;
    logic          ovf_q, accept, drop, pop;

    // Count valid lanes and give each valid lane its slot relative to the write pointer
    always_comb begin
        k = '0;
        for (int l = 0; l < NRET; l++) begin
            lane_idx[l] = wptr_q + k[AW-1:0];
            k = k + CW'(valid_i[l]);
        end
    end

    // Free space is judged at cycle start, so a same-cycle pop never makes room
    assign free     = CW'(DEPTH) - count_q;
    assign accept   = (k != '0) && (k <= free);
    assign drop     = k > free;
    assign pop      = (count_q != '0) && out_ready_i;
    assign drop_sum = {1'b0, drop_q} + 17'(k);
    assign drop_sat = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

    // Pointer, occupancy and drop bookkeeping; flush outranks all traffic
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            drop_q  <= '0;
        end else if (flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            drop_q  <= '0;
        end else begin
            wptr_q  <= accept ? wptr_q + k[AW-1:0] : wptr_q;
            rptr_q  <= rptr_q + AW'(pop);
            count_q <= count_q + (accept ? k : '0) - CW'(pop);
            ovf_q   <= ovf_q | drop;
            drop_q  <= drop ? drop_sat : drop_q;
        end
    end

    // Record storage is left unreset; only the occupancy qualifies its contents
    always_ff @(posedge clk_i) begin
        if (accept && !flush_i) begin
            for (int l = 0; l < NRET; l++) begin
                if (valid_i[l]) begin
                    mem_order[lane_idx[l]] <= order_i[l*64 +: 64];
                    mem_insn[lane_idx[l]]  <= insn_i[l*32 +: 32];
                    mem_trap[lane_idx[l]]  <= trap_i[l];
                    mem_pc[lane_idx[l]]    <= pc_rdata_i[l*XLEN +: XLEN];
                    mem_rd[lane_idx[l]]    <= rd_addr_i[l*5 +: 5];
                    mem_wdata[lane_idx[l]] <= rd_wdata_i[l*XLEN +: XLEN];
                    mem_addr[lane_idx[l]]  <= mem_addr_i[l*XLEN +: XLEN];
                    mem_wmask[lane_idx[l]] <= mem_wmask_i[l*MW +: MW];
                end
            end
        end
    end

    assign out_valid_o     = count_q != '0;
    assign out_order_o     = mem_order[rptr_q];
    assign out_insn_o      = mem_insn[rptr_q];
    assign out_trap_o      = mem_trap[rptr_q];
    assign out_pc_o        = mem_pc[rptr_q];
    assign out_rd_addr_o   = mem_rd[rptr_q];
    assign out_rd_wdata_o  = mem_wdata[rptr_q];
    assign out_mem_addr_o  = mem_addr[rptr_q];
    assign out_mem_wmask_o = mem_wmask[rptr_q];
    assign count_o         = count_q;
    assign overflow_o      = ovf_q;
    assign drop_cnt_o      = drop_q;

`ifdef RVFI_ORDER_CHECK_EN
    logic [63:0] exp_q, exp_d;
    logic        err_q, err_d;

    // Walk valid lanes in order; every lane resyncs the expectation, only kept batches can flag a gap
    always_comb begin
        exp_d = exp_q;
        err_d = err_q;
        for (int l = 0; l < NRET; l++) begin
            if (valid_i[l]) begin
                if (accept && order_i[l*64 +: 64] != exp_d) err_d = 1'b1;
                exp_d = order_i[l*64 +: 64] + 64'd1;
            end
        end
    end

    // Expected-order and sticky error registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            exp_q <= '0;
            err_q <= 1'b0;
        end else if (flush_i) begin
            exp_q <= '0;
            err_q <= 1'b0;
        end else begin
            exp_q <= exp_d;
            err_q <= err_d;
        end
    end

    assign order_err_o = err_q;
`else
    assign order_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_rvfi_retire_fifo.sv
// tb_rvfi_retire_fifo: directed self-checking bench for rvfi_retire_fifo (NRET=2, DEPTH=8).
module tb_rvfi_retire_fifo;
    localparam int NRET  = 2;
    localparam int XLEN  = 64;
    localparam int DEPTH = 8;
`ifdef RVFI_ORDER_CHECK_EN
    localparam bit EXP_ERR = 1'b1;
`else
    localparam bit EXP_ERR = 1'b0;
`endif

    logic                   clk_i = 1'b0;
    logic                   rst_ni;
    logic                   flush_i;
    logic [NRET-1:0]        valid_i;
    logic [NRET*64-1:0]     order_i;
    logic [NRET*32-1:0]     insn_i;
    logic [NRET-1:0]        trap_i;
    logic [NRET*XLEN-1:0]   pc_rdata_i;
    logic [NRET*5-1:0]      rd_addr_i;
    logic [NRET*XLEN-1:0]   rd_wdata_i;
    logic [NRET*XLEN-1:0]   mem_addr_i;
    logic [NRET*XLEN/8-1:0] mem_wmask_i;
    logic                   out_valid_o;
    logic                   out_ready_i;
    logic [63:0]            out_order_o;
    logic [31:0]            out_insn_o;
    logic                   out_trap_o;
    logic [XLEN-1:0]        out_pc_o;
    logic [4:0]             out_rd_addr_o;
    logic [XLEN-1:0]        out_rd_wdata_o;
    logic [XLEN-1:0]        out_mem_addr_o;
    logic [XLEN/8-1:0]      out_mem_wmask_o;
    logic [3:0]             count_o;
    logic                   overflow_o;
    logic [15:0]            drop_cnt_o;
    logic                   order_err_o;

    int vectors = 0;
    int miscompares = 0;

    rvfi_retire_fifo #(.NRET(NRET), .XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .valid_i(valid_i),
        .order_i(order_i), .insn_i(insn_i), .trap_i(trap_i), .pc_rdata_i(pc_rdata_i),
        .rd_addr_i(rd_addr_i), .rd_wdata_i(rd_wdata_i), .mem_addr_i(mem_addr_i),
        .mem_wmask_i(mem_wmask_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_order_o(out_order_o), .out_insn_o(out_insn_o), .out_trap_o(out_trap_o),
        .out_pc_o(out_pc_o), .out_rd_addr_o(out_rd_addr_o), .out_rd_wdata_o(out_rd_wdata_o),
        .out_mem_addr_o(out_mem_addr_o), .out_mem_wmask_o(out_mem_wmask_o),
        .count_o(count_o), .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o),
        .order_err_o(order_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic clear_lanes();
        valid_i = '0; order_i = '0; insn_i = '0; trap_i = '0; pc_rdata_i = '0;
        rd_addr_i = '0; rd_wdata_i = '0; mem_addr_i = '0; mem_wmask_i = '0;
    endtask

    // Every field is a fixed function of the order so the expected head is easy to write down
    task automatic set_lane(input int l, input logic [63:0] o);
        valid_i[l] = 1'b1;
        order_i[l*64 +: 64] = o;
        insn_i[l*32 +: 32] = 32'hA500_0000 ^ o[31:0];
        trap_i[l] = o[0];
        pc_rdata_i[l*64 +: 64] = 64'h8000_0000 + (o << 2);
        rd_addr_i[l*5 +: 5] = o[4:0];
        rd_wdata_i[l*64 +: 64] = ~o;
        mem_addr_i[l*64 +: 64] = o << 8;
        mem_wmask_i[l*8 +: 8] = o[7:0];
    endtask

    task automatic test_reset();
        @(negedge clk_i);
        vectors++; if (count_o !== 4'd0) begin miscompares++; $display("FAIL reset_count: got %0d expected 0", count_o); end
        vectors++; if (out_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", out_valid_o); end
        vectors++; if (overflow_o !== 1'b0) begin miscompares++; $display("FAIL reset_overflow: got %b expected 0", overflow_o); end
        vectors++; if (drop_cnt_o !== 16'd0) begin miscompares++; $display("FAIL reset_drop: got %0d expected 0", drop_cnt_o); end
        vectors++; if (order_err_o !== 1'b0) begin miscompares++; $display("FAIL reset_order_err: got %b expected 0", order_err_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic test_basic();
        out_ready_i = 1'b1;
        set_lane(0, 64'd0); set_lane(1, 64'd1);
        step();
        clear_lanes();
        vectors++; if (count_o !== 4'd2) begin miscompares++; $display("FAIL basic_count_peak: got %0d expected 2", count_o); end
        vectors++; if (out_valid_o !== 1'b1) begin miscompares++; $display("FAIL basic_valid0: got %b expected 1", out_valid_o); end
        vectors++; if (out_order_o !== 64'd0) begin miscompares++; $display("FAIL basic_order0: got %0d expected 0", out_order_o); end
        vectors++; if (out_pc_o !== 64'h8000_0000) begin miscompares++; $display("FAIL basic_pc0: got %h expected 80000000", out_pc_o); end
        vectors++; if (out_trap_o !== 1'b0) begin miscompares++; $display("FAIL basic_trap0: got %b expected 0", out_trap_o); end
        step();
        vectors++; if (count_o !== 4'd1) begin miscompares++; $display("FAIL basic_count1: got %0d expected 1", count_o); end
        vectors++; if (out_order_o !== 64'd1) begin miscompares++; $display("FAIL basic_order1: got %0d expected 1", out_order_o); end
        vectors++; if (out_insn_o !== 32'hA500_0001) begin miscompares++; $display("FAIL basic_insn1: got %h expected a5000001", out_insn_o); end
        vectors++; if (out_trap_o !== 1'b1) begin miscompares++; $display("FAIL basic_trap1: got %b expected 1", out_trap_o); end
        vectors++; if (out_pc_o !== 64'h8000_0004) begin miscompares++; $display("FAIL basic_pc1: got %h expected 80000004", out_pc_o); end
        vectors++; if (out_rd_addr_o !== 5'd1) begin miscompares++; $display("FAIL basic_rd1: got %0d expected 1", out_rd_addr_o); end
        vectors++; if (out_rd_wdata_o !== 64'hFFFF_FFFF_FFFF_FFFE) begin miscompares++; $display("FAIL basic_wdata1: got %h expected fffffffffffffffe", out_rd_wdata_o); end
        vectors++; if (out_mem_addr_o !== 64'h100) begin miscompares++; $display("FAIL basic_maddr1: got %h expected 100", out_mem_addr_o); end
        vectors++; if (out_mem_wmask_o !== 8'h01) begin miscompares++; $display("FAIL basic_wmask1: got %h expected 01", out_mem_wmask_o); end
        step();
        vectors++; if (out_valid_o !== 1'b0) begin miscompares++; $display("FAIL basic_drained: got %b expected 0", out_valid_o); end
    endtask

    task automatic test_overflow();
        out_ready_i = 1'b0;
        for (int b = 0; b < 4; b++) begin
            clear_lanes(); set_lane(0, 64'(2 + 2*b)); set_lane(1, 64'(3 + 2*b));
            step();
        end
        clear_lanes();
        vectors++; if (count_o !== 4'd8) begin miscompares++; $display("FAIL ovf_full_count: got %0d expected 8", count_o); end
        vectors++; if (overflow_o !== 1'b0) begin miscompares++; $display("FAIL ovf_not_yet: got %b expected 0", overflow_o); end
        set_lane(0, 64'd10); set_lane(1, 64'd11);
        step();
        clear_lanes();
        vectors++; if (count_o !== 4'd8) begin miscompares++; $display("FAIL ovf_count_held: got %0d expected 8", count_o); end
        vectors++; if (overflow_o !== 1'b1) begin miscompares++; $display("FAIL ovf_flag: got %b expected 1", overflow_o); end
        vectors++; if (drop_cnt_o !== 16'd2) begin miscompares++; $display("FAIL ovf_drop2: got %0d expected 2", drop_cnt_o); end
        vectors++; if (out_order_o !== 64'd2) begin miscompares++; $display("FAIL ovf_head_stable: got %0d expected 2", out_order_o); end
    endtask

    task automatic test_full_pop_push();
        out_ready_i = 1'b1;
        set_lane(0, 64'd12);
        step();
        clear_lanes();
        out_ready_i = 1'b0;
        vectors++; if (count_o !== 4'd7) begin miscompares++; $display("FAIL fpp_count: got %0d expected 7", count_o); end
        vectors++; if (drop_cnt_o !== 16'd3) begin miscompares++; $display("FAIL fpp_drop: got %0d expected 3", drop_cnt_o); end
        vectors++; if (out_order_o !== 64'd3) begin miscompares++; $display("FAIL fpp_head: got %0d expected 3", out_order_o); end
    endtask

    task automatic test_flush();
        out_ready_i = 1'b1;
        step(); step();
        out_ready_i = 1'b0;
        vectors++; if (count_o !== 4'd5) begin miscompares++; $display("FAIL flush_pre_count: got %0d expected 5", count_o); end
        vectors++; if (out_order_o !== 64'd5) begin miscompares++; $display("FAIL flush_pre_head: got %0d expected 5", out_order_o); end
        flush_i = 1'b1;
        set_lane(0, 64'd50); set_lane(1, 64'd51);
        step();
        flush_i = 1'b0;
        clear_lanes();
        vectors++; if (count_o !== 4'd0) begin miscompares++; $display("FAIL flush_count: got %0d expected 0", count_o); end
        vectors++; if (out_valid_o !== 1'b0) begin miscompares++; $display("FAIL flush_valid: got %b expected 0", out_valid_o); end
        vectors++; if (overflow_o !== 1'b0) begin miscompares++; $display("FAIL flush_overflow: got %b expected 0", overflow_o); end
        vectors++; if (drop_cnt_o !== 16'd0) begin miscompares++; $display("FAIL flush_drop: got %0d expected 0", drop_cnt_o); end
        step();
        vectors++; if (count_o !== 4'd0) begin miscompares++; $display("FAIL flush_discard: got %0d expected 0", count_o); end
    endtask

    task automatic test_reset_midstream();
        out_ready_i = 1'b0;
        set_lane(0, 64'd100); set_lane(1, 64'd101);
        step();
        clear_lanes();
        vectors++; if (count_o !== 4'd2) begin miscompares++; $display("FAIL rst_mid_pre: got %0d expected 2", count_o); end
        set_lane(0, 64'd102);
        #2 rst_ni = 1'b0;
        #1;
        vectors++; if (count_o !== 4'd0) begin miscompares++; $display("FAIL rst_mid_count: got %0d expected 0", count_o); end
        vectors++; if (out_valid_o !== 1'b0) begin miscompares++; $display("FAIL rst_mid_valid: got %b expected 0", out_valid_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        clear_lanes();
        step();
        vectors++; if (count_o !== 4'd0) begin miscompares++; $display("FAIL rst_mid_after: got %0d expected 0", count_o); end
    endtask

    task automatic test_order_check();
        out_ready_i = 1'b1;
        set_lane(0, 64'd0); set_lane(1, 64'd1);
        step();
        clear_lanes();
        vectors++; if (order_err_o !== 1'b0) begin miscompares++; $display("FAIL order_in_seq: got %b expected 0", order_err_o); end
        set_lane(0, 64'd3);
        step();
        clear_lanes();
        vectors++; if (order_err_o !== EXP_ERR) begin miscompares++; $display("FAIL order_gap: got %b expected %b", order_err_o, EXP_ERR); end
        set_lane(0, 64'd4);
        step();
        clear_lanes();
        vectors++; if (order_err_o !== EXP_ERR) begin miscompares++; $display("FAIL order_sticky: got %b expected %b", order_err_o, EXP_ERR); end
        step(); step(); step();
        vectors++; if (count_o !== 4'd0) begin miscompares++; $display("FAIL order_drain: got %0d expected 0", count_o); end
    endtask

    task automatic test_wrap();
        int sent = 0;
        int rcv = 0;
        for (int c = 0; c < 64; c++) begin
            out_ready_i = c[0];
            clear_lanes();
            if (c % 4 == 0 && sent < 20) begin
                set_lane(0, 64'(sent)); set_lane(1, 64'(sent + 1));
                sent += 2;
            end
            if (out_valid_o && out_ready_i) begin
                vectors++;
                if (out_order_o !== 64'(rcv) || out_pc_o !== 64'h8000_0000 + 64'(rcv * 4)) begin
                    miscompares++;
                    $display("FAIL wrap_seq: got order %0d pc %h expected order %0d", out_order_o, out_pc_o, rcv);
                end
                rcv++;
            end
            step();
        end
        clear_lanes();
        out_ready_i = 1'b0;
        vectors++; if (rcv !== 20) begin miscompares++; $display("FAIL wrap_received: got %0d expected 20", rcv); end
        vectors++; if (drop_cnt_o !== 16'd0) begin miscompares++; $display("FAIL wrap_drop: got %0d expected 0", drop_cnt_o); end
        vectors++; if (overflow_o !== 1'b0) begin miscompares++; $display("FAIL wrap_overflow: got %b expected 0", overflow_o); end
        vectors++; if (count_o !== 4'd0) begin miscompares++; $display("FAIL wrap_empty: got %0d expected 0", count_o); end
    endtask

    initial begin
        rst_ni = 1'b0;
        flush_i = 1'b0;
        out_ready_i = 1'b0;
        clear_lanes();
        test_reset();
        test_basic();
        test_overflow();
        test_full_pop_push();
        test_flush();
        test_reset_midstream();
        test_order_check();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/rvfi_retire_fifo.md
RVFI_RETIRE_FIFO -- requirements
Module: rvfi_retire_fifo

Interface
Parameters (name, default, meaning):
- REQ-001 SHALL have NRET, 1, number of parallel retire lanes (1..4).
- REQ-002 SHALL have XLEN, 64, data/address width.
- REQ-003 SHALL have DEPTH, 8, record entries; power of two, >= 2*NRET.

Ports (name, direction, width, meaning):
- REQ-004 SHALL have clk_i, in, 1, sole clock, rising edge.
- REQ-005 SHALL have rst_ni, in, 1, asynchronous active-low reset.
- REQ-006 SHALL have flush_i, in, 1, synchronous empty-and-clear.
- REQ-007 SHALL have valid_i, in, NRET, per-lane retire valid.
- REQ-008 SHALL have order_i, in, NRET*64, per-lane retire order.
- REQ-009 SHALL have insn_i, in, NRET*32, per-lane instruction word.
- REQ-010 SHALL have trap_i, in, NRET, per-lane trap flag.
- REQ-011 SHALL have pc_rdata_i, in, NRET*XLEN, per-lane PC.
- REQ-012 SHALL have rd_addr_i, in, NRET*5, per-lane destination register.
- REQ-013 SHALL have rd_wdata_i, in, NRET*XLEN, per-lane write data.
- REQ-014 SHALL have mem_addr_i, in, NRET*XLEN, per-lane memory address.
- REQ-015 SHALL have mem_wmask_i, in, NRET*XLEN/8, per-lane store byte mask.
- REQ-016 SHALL have out_valid_o, out, 1, head record valid.
- REQ-017 SHALL have out_ready_i, in, 1, consumer accepts head.
- REQ-018 SHALL have out_order_o/out_insn_o/out_trap_o/out_pc_o/out_rd_addr_o/out_rd_wdata_o/out_mem_addr_o/out_mem_wmask_o, out, 64/32/1/XLEN/5/XLEN/XLEN/XLEN/8, head record fields.
- REQ-019 SHALL have count_o, out, $clog2(DEPTH)+1, occupancy.
- REQ-020 SHALL have overflow_o, out, 1, sticky drop flag.
- REQ-021 SHALL have drop_cnt_o, out, 16, dropped records, saturating at 16'hFFFF.
- REQ-022 SHALL have order_err_o, out, 1, sticky order-gap flag.

Function
- REQ-023 Per cycle, k = popcount(valid_i); if k <= DEPTH-count at cycle start, SHALL push all valid lanes in ascending lane order, skipping invalid lanes.
- REQ-024 If k > free slots, SHALL drop the whole batch (no partial push), set overflow_o, add k to drop_cnt_o (saturating).
- REQ-025 Concurrent pop SHALL NOT create free space for the same cycle's push.
- REQ-026 out_valid_o SHALL equal (count_o != 0); head fields SHALL come from FIFO storage, giving push-to-output latency of 1 cycle.
- REQ-027 Pop occurs when out_valid_o && out_ready_i, one record per cycle; head fields SHALL stay stable while out_valid_o && !out_ready_i.
- REQ-028 count_o SHALL update as count + pushed - popped; pointers SHALL wrap modulo DEPTH.
- REQ-029 Pop on empty SHALL have no effect; push when exactly full with k=0 SHALL have no effect.
- REQ-030 flush_i SHALL take priority: pointers and count_o go to 0, overflow_o/order_err_o/drop_cnt_o are cleared, and same-cycle input is discarded.

Reset
- REQ-031 On rst_ni low, SHALL asynchronously clear count_o, the pointers, overflow_o, drop_cnt_o, order_err_o, and the expected order to 0; out_valid_o SHALL be 0.
- REQ-032 Storage SHALL NOT be reset; out_* data is don't-care while out_valid_o is 0.
- REQ-033 Reset asserted mid-transfer SHALL discard all contents without emitting partial records.

Configuration
- REQ-034 Macro RVFI_ORDER_CHECK_EN defined: SHALL compare each pushed record's order with the expected order, lanes in sequence; on mismatch SHALL set order_err_o, then resync expected = order+1; on match expected increments; dropped batches SHALL resync expected to the last dropped order+1.
- REQ-035 Macro undefined: SHALL omit the checker; order_err_o SHALL be tied to 0.

Verification
- REQ-036 NRET=2, DEPTH=8: valid_i=2'b11, orders 0,1, out_ready_i=1 -> out order 0 at cycle+1, then 1 at cycle+2; count_o peaks at 2.
- REQ-037 out_ready_i=0, 4 cycles of valid_i=2'b11 -> count_o=8; 5th batch -> count_o stays 8, overflow_o=1, drop_cnt_o=2.
- REQ-038 Full FIFO, out_ready_i=1, valid_i=2'b01 same cycle -> batch dropped, count_o=7, drop_cnt_o increments by 1.
- REQ-039 RVFI_ORDER_CHECK_EN, orders 0,1,3 -> order_err_o=1 after the push of 3; next order 4 -> no new error, flag stays sticky.
- REQ-040 Wrap: stream 20 records with the consumer stalling every other cycle -> output orders are 0..19 in sequence, nothing dropped.
- REQ-041 flush_i with count_o=5 and overflow_o=1 -> next cycle count_o=0, out_valid_o=0, overflow_o=0, drop_cnt_o=0.
